uart_word_tx: RTL and testbench



---
 rtl/uart_word_tx_if.sv | 27 ++
 rtl/uart_word_tx.sv | 118 +++++++++++
 tb/tb_uart_word_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_word_tx_if.sv
// Handshake bundle between the TX data register side and the serializer.
// The master owns the word and start strobe; the slave drives the line and status.
interface uart_word_tx_if #(
  parameter int N = 8
);
  logic [N-1:0] D;
  logic         start;
  logic         tx;
  logic         busy;
  logic         done;

  modport master (
    output D,
    output start,
    input  tx,
    input  busy,
    input  done
  );

  modport slave (
    input  D,
    input  start,
    output tx,
    output busy,
    output done
  );
endinterface

// File: rtl/uart_word_tx.sv
// Word-to-serial transmitter: start bit, N data bits LSB-first, stop bit,
// each bit held CLKS_PER_BIT clocks. All outputs come straight from registers.
module uart_word_tx #(
  parameter int N            = 8,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           clk,
  input  logic           rst,
  uart_word_tx_if.slave  bus
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] cnt_reg,   cnt_next;
  logic [BW-1:0] bit_reg,   bit_next;
  logic [N-1:0]  shift_reg, shift_next;
  logic          tx_reg,    tx_next;
  logic          busy_reg,  busy_next;
  logic          done_reg,  done_next;
  logic          bit_end;

  assign bit_end = (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = START;
          shift_next = bus.D;
          cnt_next   = '0;
          tx_next    = 1'b0;
          busy_next  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          cnt_next   = '0;
          bit_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_next   = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == BIT_LAST) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_next = bit_reg + BW'(1);
            // Next data bit is whatever lands in bit 0 after this shift.
            tx_next  = shift_next[0];
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.tx   = tx_reg;
  assign bus.busy = busy_reg;
  assign bus.done = done_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Bench for uart_word_tx: three parameterisations driven side by side, a
// frame-level reference model checked every cycle, plus directed vectors.
module tb_uart_word_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int pn[3] = '{8, 1, 32};
  int pc[3] = '{4, 2, 3};

  logic [31:0] dv[3];
  logic        st[3];
  logic        o_tx[3], o_busy[3], o_done[3];

  uart_word_tx_if #(.N(8))  bus0();
  uart_word_tx_if #(.N(1))  bus1();
  uart_word_tx_if #(.N(32)) bus2();

  assign bus0.D = dv[0][7:0];
  assign bus1.D = dv[1][0:0];
  assign bus2.D = dv[2];
  assign bus0.start = st[0];
  assign bus1.start = st[1];
  assign bus2.start = st[2];
  assign o_tx[0] = bus0.tx;  assign o_busy[0] = bus0.busy;  assign o_done[0] = bus0.done;
  assign o_tx[1] = bus1.tx;  assign o_busy[1] = bus1.busy;  assign o_done[1] = bus1.done;
  assign o_tx[2] = bus2.tx;  assign o_busy[2] = bus2.busy;  assign o_done[2] = bus2.done;

  uart_word_tx #(.N(8),  .CLKS_PER_BIT(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  uart_word_tx #(.N(1),  .CLKS_PER_BIT(2)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  uart_word_tx #(.N(32), .CLKS_PER_BIT(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  // Reference: a frame is just "elapsed cycles since acceptance"; the line
  // value follows from which bit period that falls in.
  int          m_el[3];
  logic [31:0] m_word[3];
  bit          m_busy[3] = '{0, 0, 0};
  bit          m_done[3] = '{0, 0, 0};

  function automatic bit exp_tx(input int i);
    int k;
    if (!m_busy[i]) return 1'b1;
    k = m_el[i] / pc[i];
    if (k == 0) return 1'b0;
    if (k <= pn[i]) return m_word[i][k-1];
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_el[i]   = 0;
      end else if (m_busy[i]) begin
        m_el[i]   = m_el[i] + 1;
        m_done[i] = 1'b0;
        if (m_el[i] == (pn[i] + 2) * pc[i]) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
          $display("frame dut%0d word=%h sent", i, m_word[i]);
        end
      end else begin
        m_done[i] = 1'b0;
        if (st[i]) begin
          m_word[i] = dv[i];
          m_el[i]   = 0;
          m_busy[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (o_tx[i] !== exp_tx(i) || o_busy[i] !== m_busy[i] || o_done[i] !== m_done[i]) begin
          bad++;
          $display("FAIL model dut%0d t=%0t got tx/busy/done=%b%b%b want %b%b%b",
                   i, $time, o_tx[i], o_busy[i], o_done[i], exp_tx(i), m_busy[i], m_done[i]);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (o_busy[d] !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", (n >= 400) ? 32'd1 : 32'd0, 32'd0);
  endtask

  typedef struct {
    int          dut;
    logic [31:0] d;
    logic [33:0] frame;    // bit j = j-th bit on the line
    int          nbits;
    int          cycles;
    int          poke_cyc;
    logic [31:0] poke_d;
  } vec_t;

  vec_t vecs[5];

  task automatic run_vec(input int idx, input vec_t v);
    int  cpb, nd, dc, got;
    bit  ok;
    bit  cap[0:255];
    cpb = pc[v.dut];
    wait_idle(v.dut);
    dv[v.dut] = v.d;
    st[v.dut] = 1'b1;
    @(negedge clk);
    st[v.dut] = 1'b0;
    check("accept_busy", o_busy[v.dut], 1);
    check("accept_tx", o_tx[v.dut], 0);
    nd = 0;
    dc = -1;
    for (int c = 0; c < v.cycles + 6; c++) begin
      cap[c] = o_tx[v.dut];
      if (o_done[v.dut] === 1'b1) begin
        nd++;
        if (dc < 0) dc = c;
      end
      st[v.dut] = (c == v.poke_cyc);
      if (c == v.poke_cyc) dv[v.dut] = v.poke_d;
      @(negedge clk);
    end
    st[v.dut] = 1'b0;
    check("done_cycle", dc, v.cycles);
    check("done_count", nd, 1);
    for (int j = 0; j < v.nbits; j++) begin
      ok  = 1'b1;
      got = v.frame[j];
      for (int k = 0; k < cpb; k++) begin
        if (ok && cap[j*cpb+k] !== v.frame[j]) begin
          ok  = 1'b0;
          got = cap[j*cpb+k];
        end
      end
      check($sformatf("vec%0d_bit%0d", idx, j), got, v.frame[j]);
    end
    check("idle_after_stop", cap[v.cycles], 1);
    $display("vec %0d dut%0d D=%h done_at=%0d dones=%0d", idx, v.dut, v.d, dc, nd);
  endtask

  initial begin
    bit cap[0:127];
    int nd;

    vecs[0] = '{dut:0, d:32'hA5, frame:{24'b0, 1'b1, 8'hA5, 1'b0}, nbits:10, cycles:40, poke_cyc:-1, poke_d:0};
    vecs[1] = '{dut:0, d:32'h3C, frame:{24'b0, 1'b1, 8'h3C, 1'b0}, nbits:10, cycles:40, poke_cyc:10, poke_d:32'hFF};
    vecs[2] = '{dut:1, d:32'h1,  frame:{31'b0, 1'b1, 1'b1, 1'b0}, nbits:3, cycles:6, poke_cyc:-1, poke_d:0};
    vecs[3] = '{dut:2, d:32'h8000_0001, frame:{1'b1, 32'h8000_0001, 1'b0}, nbits:34, cycles:102, poke_cyc:-1, poke_d:0};
    vecs[4] = '{dut:0, d:32'h81, frame:{24'b0, 1'b1, 8'h81, 1'b0}, nbits:10, cycles:40, poke_cyc:-1, poke_d:0};

    // Reset held with start asserted: outputs stay idle, first edge after release accepts.
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b1;
      dv[i] = 32'h0000_005A;
    end
    #1 rst = 1'b0;
    chk_on = 1'b1;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check("rst_tx", o_tx[i], 1);
        check("rst_busy", o_busy[i], 0);
        check("rst_done", o_done[i], 0);
      end
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      check("release_accept_busy", o_busy[i], 1);
      check("release_accept_tx", o_tx[i], 0);
    end

    for (int v = 0; v < 4; v++) run_vec(v, vecs[v]);

    // Back-to-back: start held, D switched mid-frame; 1 idle cycle between frames.
    wait_idle(0);
    dv[0] = 32'h00;
    st[0] = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 84; c++) begin
      cap[c] = o_tx[0];
      if (c == 5)  dv[0] = 32'hFF;
      if (c == 60) st[0] = 1'b0;
      @(negedge clk);
    end
    check("b2b_f1_data", {cap[4], cap[19], cap[35]}, 0);
    check("b2b_f1_stop", cap[39], 1);
    check("b2b_gap", cap[40], 1);
    check("b2b_f2_start", cap[41], 0);
    check("b2b_f2_data", {cap[45], cap[60], cap[76]}, 3'b111);
    check("b2b_f2_stop", cap[80], 1);
    $display("b2b dut0 frames 00 then FF");

    // Reset during data bit 3 of 8'h55.
    wait_idle(0);
    dv[0] = 32'h55;
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (17) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst_tx", o_tx[0], 1);
    check("midrst_busy", o_busy[0], 0);
    check("midrst_done", o_done[0], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    nd = 0;
    repeat (45) begin
      @(negedge clk);
      if (o_done[0] === 1'b1) nd++;
    end
    check("midrst_no_done", nd, 0);
    $display("midrst dut0 frame 55 abandoned");
    run_vec(4, vecs[4]);

    // Random traffic on all three instances against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        dv[i] = $urandom;
        st[i] = ($urandom_range(0, 9) == 0);
      end
    end
    for (int i = 0; i < 3; i++) st[i] = 1'b0;
    for (int i = 0; i < 3; i++) wait_idle(i);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
